// File: rtl/cpu_isa_pkg.sv
// cpu_isa_pkg: shared ISA constants, instruction field widths and fetch FSM state type
package cpu_isa_pkg;

    localparam int PC_W   = 16;
    localparam int INST_W = 9;
    localparam int OP_W   = 5;
    localparam int OPND_W = INST_W - OP_W;

    localparam logic [OP_W-1:0] OP_ADD  = 5'b00000;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00001;
    localparam logic [OP_W-1:0] OP_AND  = 5'b00010;
    localparam logic [OP_W-1:0] OP_OR   = 5'b00011;
    localparam logic [OP_W-1:0] OP_XOR  = 5'b00100;
    localparam logic [OP_W-1:0] OP_LD   = 5'b01000;
    localparam logic [OP_W-1:0] OP_ST   = 5'b01001;
    localparam logic [OP_W-1:0] OP_BEQ  = 5'b10000;
    localparam logic [OP_W-1:0] OP_JMP  = 5'b10100;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11010;
    localparam logic [OP_W-1:0] OP_TBD  = 5'b11011;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        HALTED
    } fetch_state_t;

endpackage

// File: rtl/fetch_perf_ctr.sv
// fetch_perf_ctr: 32-bit saturating event counter with synchronous clear
module fetch_perf_ctr (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clr,
    input  logic        i_inc,
    output logic [31:0] o_cnt
);

    logic [31:0] r_cnt;

    assign o_cnt = r_cnt;

    // count events, sticking at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_inc && r_cnt != '1)
            r_cnt <= r_cnt + 32'd1;
    end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: IF stage controller feeding the IF/ID slot; optional FETCH_PERF_EN adds perf counters
module fetch_sequencer
    import cpu_isa_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter int              INST_W   = 9,
    parameter int              OP_W     = 5,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [PC_W-1:0]   rom_pc,
    input  logic [INST_W-1:0] rom_inst,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [INST_W-1:0] id_inst,
    output logic [PC_W-1:0]   id_pc,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              busy,
    output logic              halted
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch,
    output logic [31:0]       perf_stall
`endif
);

    fetch_state_t      r_state, w_state_nx;
    logic [PC_W-1:0]   r_rom_pc, w_rom_pc_nx;
    logic [PC_W-1:0]   r_id_pc, w_id_pc_nx;
    logic [INST_W-1:0] r_id_inst, w_id_inst_nx;
    logic              r_id_valid, w_id_valid_nx;
    logic              w_fill;
    logic              w_is_halt;

    assign rom_pc    = r_rom_pc;
    assign id_pc     = r_id_pc;
    assign id_inst   = r_id_inst;
    assign id_valid  = r_id_valid;
    assign busy      = (r_state == FETCH) || (r_state == DRAIN);
    assign halted    = (r_state == HALTED);
    assign w_is_halt = rom_inst[INST_W-1 -: OP_W] == OP_W'(OP_HALT);
    assign w_fill    = (r_state == FETCH) && !redirect && (!r_id_valid || id_ready);

    // state and IF/ID slot registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_rom_pc   <= RESET_PC;
            r_id_pc    <= '0;
            r_id_inst  <= '0;
            r_id_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_rom_pc   <= w_rom_pc_nx;
            r_id_pc    <= w_id_pc_nx;
            r_id_inst  <= w_id_inst_nx;
            r_id_valid <= w_id_valid_nx;
        end
    end

    // next state: redirect outranks fill and halt detection; a halt fill parks the PC
    always_comb begin
        w_state_nx    = r_state;
        w_rom_pc_nx   = r_rom_pc;
        w_id_pc_nx    = r_id_pc;
        w_id_inst_nx  = r_id_inst;
        w_id_valid_nx = r_id_valid;
        case (r_state)
            IDLE, HALTED: begin
                if (start) begin
                    w_rom_pc_nx   = RESET_PC;
                    w_id_valid_nx = 1'b0;
                    w_state_nx    = FETCH;
                end
            end
            FETCH, DRAIN: begin
                if (redirect) begin
                    w_id_valid_nx = 1'b0;
                    w_rom_pc_nx   = redirect_pc;
                    w_state_nx    = FETCH;
                end else if (w_fill) begin
                    w_id_inst_nx  = rom_inst;
                    w_id_pc_nx    = r_rom_pc;
                    w_id_valid_nx = 1'b1;
                    w_rom_pc_nx   = w_is_halt ? r_rom_pc : r_rom_pc + PC_W'(1);
                    w_state_nx    = w_is_halt ? DRAIN : FETCH;
                end else if (r_state == DRAIN && r_id_valid && id_ready) begin
                    w_id_valid_nx = 1'b0;
                    w_state_nx    = HALTED;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

`ifdef FETCH_PERF_EN
    logic w_start_go;
    logic w_stall;

    assign w_start_go = start && (r_state == IDLE || r_state == HALTED);
    assign w_stall    = (r_state == FETCH) && r_id_valid && !id_ready;

    fetch_perf_ctr u_perf_fetch (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_start_go),
        .i_inc (w_fill),
        .o_cnt (perf_fetch)
    );

    fetch_perf_ctr u_perf_stall (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_start_go),
        .i_inc (w_stall),
        .o_cnt (perf_stall)
    );
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed table-driven and sequence checks for fetch_sequencer
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] rom_pc;
    logic [8:0]  rom_inst;
    logic        id_valid;
    logic        id_ready;
    logic [8:0]  id_inst;
    logic [15:0] id_pc;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        busy;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_stall;
`endif

    logic        halt_en;
    logic [15:0] halt_addr;
    int          n_checks;
    int          n_fail;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .rom_pc      (rom_pc),
        .rom_inst    (rom_inst),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_inst     (id_inst),
        .id_pc       (id_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .busy        (busy),
        .halted      (halted)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch  (perf_fetch),
        .perf_stall  (perf_stall)
`endif
    );

    function automatic logic [8:0] rom_model(input logic [15:0] pc);
        return (halt_en && pc == halt_addr) ? {5'b11010, 4'b0000} : {5'b00001, pc[3:0]};
    endfunction

    assign rom_inst = rom_model(rom_pc);

    typedef struct {
        logic        start;
        logic        ready;
        logic        redir;
        logic [15:0] redir_pc;
        logic        exp_valid;
        logic [15:0] exp_id_pc;
        logic [15:0] exp_rom_pc;
        logic        exp_busy;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input logic s, input logic r, input logic rd, input logic [15:0] rp,
                                input logic v, input logic [15:0] ip, input logic [15:0] pc, input logic b);
        vec_t t;
        t.start = s; t.ready = r; t.redir = rd; t.redir_pc = rp;
        t.exp_valid = v; t.exp_id_pc = ip; t.exp_rom_pc = pc; t.exp_busy = b;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic s, input logic r, input logic rd, input logic [15:0] rp);
        start = s; id_ready = r; redirect = rd; redirect_pc = rp;
        @(posedge clk);
        #1;
        start = 1'b0; redirect = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        halt_en = 1'b0; halt_addr = 16'h0051;
        rst_n = 1'b0; start = 1'b0; id_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;

        vecs[0]  = mk(1, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1);
        vecs[1]  = mk(0, 1, 0, 16'h0000, 1, 16'h0000, 16'h0001, 1);
        vecs[2]  = mk(0, 1, 0, 16'h0000, 1, 16'h0001, 16'h0002, 1);
        vecs[3]  = mk(0, 1, 0, 16'h0000, 1, 16'h0002, 16'h0003, 1);
        vecs[4]  = mk(0, 1, 0, 16'h0000, 1, 16'h0003, 16'h0004, 1);
        vecs[5]  = mk(0, 0, 0, 16'h0000, 1, 16'h0003, 16'h0004, 1);
        vecs[6]  = mk(0, 0, 0, 16'h0000, 1, 16'h0003, 16'h0004, 1);
        vecs[7]  = mk(0, 0, 0, 16'h0000, 1, 16'h0003, 16'h0004, 1);
        vecs[8]  = mk(0, 1, 0, 16'h0000, 1, 16'h0004, 16'h0005, 1);
        vecs[9]  = mk(0, 1, 1, 16'h0049, 0, 16'h0004, 16'h0049, 1);
        vecs[10] = mk(0, 1, 0, 16'h0000, 1, 16'h0049, 16'h004A, 1);
        vecs[11] = mk(0, 0, 1, 16'h0044, 0, 16'h0049, 16'h0044, 1);
        vecs[12] = mk(0, 1, 0, 16'h0000, 1, 16'h0044, 16'h0045, 1);

        repeat (2) @(posedge clk);
        #1;
        check("reset rom_pc", rom_pc, 32'h0);
        check("reset id_valid", id_valid, 32'h0);
        check("reset id_inst", id_inst, 32'h0);
        check("reset id_pc", id_pc, 32'h0);
        check("reset busy", busy, 32'h0);
        check("reset halted", halted, 32'h0);
        rst_n = 1'b1;
        step(0, 1, 0, 16'h0000);
        check("idle no fetch", id_valid, 32'h0);

        for (int i = 0; i < 13; i++) begin
            step(vecs[i].start, vecs[i].ready, vecs[i].redir, vecs[i].redir_pc);
            check($sformatf("v%0d id_valid", i), id_valid, vecs[i].exp_valid);
            check($sformatf("v%0d id_pc", i), id_pc, vecs[i].exp_id_pc);
            check($sformatf("v%0d rom_pc", i), rom_pc, vecs[i].exp_rom_pc);
            check($sformatf("v%0d busy", i), busy, vecs[i].exp_busy);
            check($sformatf("v%0d halted", i), halted, 32'h0);
            if (vecs[i].exp_valid)
                check($sformatf("v%0d id_inst", i), id_inst, rom_model(vecs[i].exp_id_pc));
`ifdef FETCH_PERF_EN
            if (i == 8) begin
                check("perf_stall", perf_stall, 32'd3);
                check("perf_fetch", perf_fetch, 32'd5);
            end
`endif
        end

        halt_en = 1'b1;
        step(0, 1, 1, 16'h0050);
        step(0, 1, 0, 16'h0000);
        check("pre-halt id_pc", id_pc, 32'h50);
        step(0, 1, 0, 16'h0000);
        check("halt id_pc", id_pc, 32'h51);
        check("halt id_inst", id_inst, {23'h0, 5'b11010, 4'b0000});
        check("halt rom_pc held", rom_pc, 32'h51);
        check("drain busy", busy, 32'h1);
        step(0, 0, 0, 16'h0000);
        check("drain stall valid", id_valid, 32'h1);
        check("drain stall halted", halted, 32'h0);
        step(0, 1, 0, 16'h0000);
        check("halted valid", id_valid, 32'h0);
        check("halted flag", halted, 32'h1);
        check("halted busy", busy, 32'h0);
        check("halted rom_pc", rom_pc, 32'h51);
        step(0, 1, 1, 16'h0010);
        check("halted redirect ignored", halted, 32'h1);
        check("halted redirect rom_pc", rom_pc, 32'h51);
        step(1, 1, 0, 16'h0000);
        check("restart rom_pc", rom_pc, 32'h0);
        check("restart busy", busy, 32'h1);
        step(0, 1, 0, 16'h0000);
        check("restart id_pc", id_pc, 32'h0);
        check("restart valid", id_valid, 32'h1);

        step(0, 1, 1, 16'h0050);
        step(0, 1, 0, 16'h0000);
        step(0, 1, 1, 16'h0020);
        check("redir over halt valid", id_valid, 32'h0);
        check("redir over halt rom_pc", rom_pc, 32'h20);
        check("redir over halt busy", busy, 32'h1);
        step(0, 1, 0, 16'h0000);
        check("redir over halt id_pc", id_pc, 32'h20);
        check("redir over halt halted", halted, 32'h0);

        step(0, 1, 1, 16'hFFFF);
        step(0, 1, 0, 16'h0000);
        check("wrap id_pc", id_pc, 32'hFFFF);
        check("wrap rom_pc", rom_pc, 32'h0);
        step(0, 1, 0, 16'h0000);
        check("wrap next id_pc", id_pc, 32'h0);

        rst_n = 1'b0;
        #1;
        check("async rst valid", id_valid, 32'h0);
        check("async rst busy", busy, 32'h0);
        check("async rst rom_pc", rom_pc, 32'h0);
        check("async rst id_pc", id_pc, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 1, 0, 16'h0000);
        step(0, 1, 0, 16'h0000);
        check("post rst idle valid", id_valid, 32'h0);
        check("post rst idle busy", busy, 32'h0);
        step(1, 1, 0, 16'h0000);
        check("latency edge1 valid", id_valid, 32'h0);
        step(0, 1, 0, 16'h0000);
        check("latency edge2 valid", id_valid, 32'h1);
        check("latency edge2 id_pc", id_pc, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
